// File: rtl/msync_pkg.sv
// Shared definitions for the multi-board sync trigger master: state encoding,
// default widths and the released (inactive) level of the active-low strobes.
package msync_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        START,
        RUN,
        STOP
    } state_t;

    localparam int CNT_W_DEF = 32;
    localparam int PW_W_DEF  = 8;

    localparam logic STROBE_IDLE = 1'b1;

endpackage

// File: rtl/msync_trigger_master.sv
// Master-side generator of the active-low nstart_daq / nstop_daq sync strobes:
// arm, wait for a trigger rising edge, delay, start strobe, run, stop strobe.
module msync_trigger_master
    import msync_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PW_W  = PW_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic             trig_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic [CNT_W-1:0] length_i,
    input  logic [PW_W-1:0]  pulse_w_i,
    output logic             nstart_daq,
    output logic             nstop_daq,
    output logic             busy_o,
    output logic             done_o
);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] delay_r;
    logic [CNT_W-1:0] length_r;
    logic [PW_W-1:0]  pw_r;
    logic [PW_W-1:0]  pw_m1;
    logic [CNT_W-1:0] w_m1;
    logic             trig_q;
    logic             trig_edge;
    logic             arm_ok;
    logic             seq_end;

    assign trig_edge = trig_i & ~trig_q;
    assign arm_ok    = (state == IDLE) && arm_i && !abort_i;

    // The shared counter holds "cycles left in this state after the current one",
    // so each phase loads its length minus one; a pulse width of 0 acts as 1.
    assign pw_m1 = (pw_r == '0) ? '0 : pw_r - 1'b1;
    assign w_m1  = CNT_W'(pw_m1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        seq_end = 1'b0;
        case (state)
            IDLE: begin
                if (arm_ok) state_n = ARMED;
            end
            ARMED: begin
                if (abort_i) begin
                    state_n = IDLE;
                    seq_end = 1'b1;
                end else if (trig_edge) begin
                    if (delay_r == '0) begin
                        state_n = START;
                        cnt_n   = w_m1;
                    end else begin
                        state_n = DELAY;
                        cnt_n   = delay_r - 1'b1;
                    end
                end
            end
            DELAY: begin
                if (abort_i) begin
                    state_n = IDLE;
                    seq_end = 1'b1;
                end else if (cnt == '0) begin
                    state_n = START;
                    cnt_n   = w_m1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            START: begin
                // A start strobe must always be followed by a full stop strobe.
                if (abort_i || (cnt == '0 && length_r == '0)) begin
                    state_n = STOP;
                    cnt_n   = w_m1;
                end else if (cnt == '0) begin
                    state_n = RUN;
                    cnt_n   = length_r - 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RUN: begin
                if (abort_i || cnt == '0) begin
                    state_n = STOP;
                    cnt_n   = w_m1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    seq_end = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            trig_q     <= 1'b0;
            delay_r    <= '0;
            length_r   <= '0;
            pw_r       <= '0;
            nstart_daq <= STROBE_IDLE;
            nstop_daq  <= STROBE_IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            trig_q     <= trig_i;
            if (arm_ok) begin
                delay_r  <= delay_i;
                length_r <= length_i;
                pw_r     <= pulse_w_i;
            end
            nstart_daq <= (state_n == START) ? ~STROBE_IDLE : STROBE_IDLE;
            nstop_daq  <= (state_n == STOP) ? ~STROBE_IDLE : STROBE_IDLE;
            busy_o     <= (state_n != IDLE);
            done_o     <= seq_end;
        end
    end

endmodule
